// File: rtl/instr_imm_decode.sv
// instr_imm_decode: I-type immediate decode stage for a MIPS pipeline.
// Accepts 32-bit instruction words, decodes opcode/rs/rt/imm plus the
// sign-extend select and I-type flag, and buffers up to two decoded
// entries in a skid FIFO so the upstream can run at full rate.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes raise out_illegal and bump illegal_count
//   undefined -> out_illegal and illegal_count are tied to zero
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on the stored count, never on in_valid, and
// out_valid depends only on the stored count, never on out_ready.
// Once out_valid is high the head entry holds steady until it is popped
// or flushed.
module instr_imm_decode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [15:0]      out_imm,
  output logic             out_sign,
  output logic             out_itype,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        sign;
    logic        itype;
    logic        illegal;
  } entry_t;

  state_t state, state_nxt;
  entry_t slot0, slot0_nxt;   // head entry
  entry_t slot1, slot1_nxt;   // entry behind the head
  entry_t dec;
  entry_t head;
  logic   accept;
  logic   pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dbg_state = state;

  // Decode the incoming word into the stored entry format.
  always_comb begin
    dec         = '0;
    dec.opcode  = in_instr[31:26];
    dec.rs      = in_instr[25:21];
    dec.rt      = in_instr[20:16];
    dec.imm     = in_instr[15:0];
    case (in_instr[31:26])
      // branches, signed arithmetic/compare, loads and stores
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        dec.sign  = 1'b1;
        dec.itype = 1'b1;
      end
      // logical immediates and lui take a zero-extended immediate
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec.itype = 1'b1;
      end
      // R-type, j, jal: known, not I-type; imm field still carried
      6'h00, 6'h02, 6'h03: begin
        dec.itype = 1'b0;
      end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`else
        dec.illegal = 1'b0;
`endif
      end
    endcase
  end

  // Next occupancy state; flush empties the buffer regardless of handshakes.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !pop)      state_nxt = FULL;
          else if (pop && !accept) state_nxt = EMPTY;
          else                     state_nxt = ONE;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Next slot contents: slot0 is always the head, slot1 shifts forward on pop.
  always_comb begin
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    if (flush) begin
      slot0_nxt = '0;
      slot1_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) slot0_nxt = dec;
        end
        ONE: begin
          if (accept && pop) begin
            slot0_nxt = dec;
          end else if (accept) begin
            slot1_nxt = dec;
          end else if (pop) begin
            slot0_nxt = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move data
          if (pop) begin
            slot0_nxt = slot1;
            slot1_nxt = '0;
          end
        end
        default: begin
          slot0_nxt = '0;
          slot1_nxt = '0;
        end
      endcase
    end
  end

  // State and storage registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      state <= state_nxt;
      slot0 <= slot0_nxt;
      slot1 <= slot1_nxt;
    end
  end

  // Present the head entry, forced to zero while nothing is buffered.
  always_comb begin
    head = '0;
    if (state != EMPTY) head = slot0;
  end

  assign out_opcode  = head.opcode;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_imm     = head.imm;
  assign out_sign    = head.sign;
  assign out_itype   = head.itype;
  assign out_illegal = head.illegal;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] ill_cnt;

  // Count accepted illegal words, saturating; flush does not clear it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (accept && !flush && dec.illegal && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + CNT_ONE;
    end
  end

  assign illegal_count = ill_cnt;
`else
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_instr_imm_decode.sv
// tb_instr_imm_decode: table-driven vectors plus directed sequences for
// instr_imm_decode, checked through an expected-entry queue.
module tb_instr_imm_decode;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_opcode;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [15:0]      out_imm;
  logic             out_sign;
  logic             out_itype;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;
  logic [1:0]       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_imm_decode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_imm(out_imm), .out_sign(out_sign), .out_itype(out_itype),
    .out_illegal(out_illegal), .illegal_count(illegal_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // record layout: {opcode, rs, rt, imm, sign, itype, illegal}
  logic [34:0] exp_q[$];
  int          exp_cnt;
  int          n_checks;
  int          n_errors;

  typedef struct {
    logic [31:0] instr;
    logic        sign;
    logic        itype;
    logic        ill;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table.
  function automatic logic [34:0] model(input logic [31:0] i);
    logic [5:0] op;
    logic       s;
    logic       it;
    logic       il;
    op = i[31:26];
    s  = 1'b0;
    it = 1'b0;
    il = 1'b0;
    case (op)
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin s = 1'b1; it = 1'b1; end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: it = 1'b1;
      6'h00, 6'h02, 6'h03: it = 1'b0;
      default: il = TRAP_EN;
    endcase
    return {op, i[25:21], i[20:16], i[15:0], s, it, il};
  endfunction

  // One clock of stimulus: check present outputs, update the model, step.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic ordy,
                       input logic fl, input logic [34:0] exp_rec);
    logic [34:0] head_act;
    logic [34:0] e;
    logic        acc;
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, exp_q.size() != 2);
    check("dbg_state", dbg_state, exp_q.size());
    check("illegal_count", illegal_count, exp_cnt);
    head_act = {out_opcode, out_rs, out_rt, out_imm, out_sign, out_itype, out_illegal};
    if (!out_valid) check("idle_fields", head_act, 0);
    acc = v && (exp_q.size() != 2) && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (ordy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("head", head_act, e);
      end
      if (acc) begin
        exp_q.push_back(exp_rec);
        if (exp_rec[0] && exp_cnt < CNT_MAX) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic ordy, input logic fl);
    cycle(v, instr, ordy, fl, model(instr));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFC00_0000;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt  = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [34:0] rec;
    logic [31:0] w;
    int          idx;
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    out_ready = 1'b0;

    vt[0]  = '{32'h1085_FFFC, 1'b1, 1'b1, 1'b0};  // beq
    vt[1]  = '{32'h14A6_8000, 1'b1, 1'b1, 1'b0};  // bne
    vt[2]  = '{32'h2008_FF00, 1'b1, 1'b1, 1'b0};  // addi
    vt[3]  = '{32'h2529_7FFF, 1'b1, 1'b1, 1'b0};  // addiu
    vt[4]  = '{32'h294A_8001, 1'b1, 1'b1, 1'b0};  // slti
    vt[5]  = '{32'h2D6B_0001, 1'b1, 1'b1, 1'b0};  // sltiu
    vt[6]  = '{32'h3108_FF00, 1'b0, 1'b1, 1'b0};  // andi
    vt[7]  = '{32'h35AD_F0F0, 1'b0, 1'b1, 1'b0};  // ori
    vt[8]  = '{32'h39CE_FFFF, 1'b0, 1'b1, 1'b0};  // xori
    vt[9]  = '{32'h3C0F_8000, 1'b0, 1'b1, 1'b0};  // lui
    vt[10] = '{32'h8D0B_0004, 1'b1, 1'b1, 1'b0};  // lw
    vt[11] = '{32'hAD0B_FFF8, 1'b1, 1'b1, 1'b0};  // sw
    vt[12] = '{32'h0123_4020, 1'b0, 1'b0, 1'b0};  // R-type
    vt[13] = '{32'h0810_0000, 1'b0, 1'b0, 1'b0};  // j
    vt[14] = '{32'h0C10_0004, 1'b0, 1'b0, 1'b0};  // jal
    vt[15] = '{32'hFC00_1234, 1'b0, 1'b0, 1'b1};  // 0x3F
    vt[16] = '{32'h0400_0001, 1'b0, 1'b0, 1'b1};  // 0x01
    vt[17] = '{32'h8000_FFFF, 1'b0, 1'b0, 1'b1};  // 0x20
    vt[18] = '{32'h4000_0000, 1'b0, 1'b0, 1'b1};  // 0x10

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state, then addi with one-cycle latency
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h2008_FF00, 1'b1, 1'b0);
    check("addi_opcode", out_opcode, 6'h08);
    check("addi_imm", out_imm, 16'hFF00);
    check("addi_sign", out_sign, 1'b1);
    check("addi_itype", out_itype, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // table vectors streamed back to back
    for (int i = 0; i < 19; i++) begin
      w   = vt[i].instr;
      rec = {w[31:26], w[25:21], w[20:16], w[15:0], vt[i].sign, vt[i].itype, vt[i].ill & TRAP_EN};
      cycle(1'b1, w, 1'b1, 1'b0, rec);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // fill with andi, lw; blocked word is ignored; drain in order
    drive(1'b1, 32'h3108_FF00, 1'b0, 1'b0);
    drive(1'b1, 32'h8D0B_0004, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("andi_sign", out_sign, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("lw_sign", out_sign, 1'b1);
    check("lw_imm", out_imm, 16'h0004);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // flush from FULL with an illegal word offered in the same cycle
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h2008_0002, 1'b0, 1'b0);
    drive(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_cnt", illegal_count, exp_cnt);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // flush from ONE with an accept+pop pending
    drive(1'b1, 32'h3C0F_1234, 1'b0, 1'b0);
    drive(1'b1, 32'h0400_0000, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, 18);
      w   = ($urandom_range(0, 1) != 0) ? (vt[idx].instr ^ ($urandom() & 32'h03FF_FFFF)) : $urandom();
      drive(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // saturation of the illegal counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'hFC00_0000 | 32'(i), 1'b1, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("sat_count", illegal_count, TRAP_EN ? CNT_MAX : 0);

    // reset while FULL with a valid word offered
    drive(1'b1, 32'h2008_0003, 1'b0, 1'b0);
    drive(1'b1, 32'hFC00_0004, 1'b0, 1'b0);
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cnt", illegal_count, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hAD0B_FFF8, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_imm_decode.md
INSTR_IMM_DECODE -- requirements
Module: instr_imm_decode

Interface
REQ-001 Parameter: CNT_W, default 8, width of the illegal-opcode counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: flush  input  1  discard all buffered instructions.
REQ-005 Port: in_valid  input  1  upstream instruction valid.
REQ-006 Port: in_ready  output  1  stage can accept an instruction.
REQ-007 Port: in_instr  input  32  MIPS instruction word.
REQ-008 Port: out_valid  output  1  decoded entry available.
REQ-009 Port: out_ready  input  1  downstream (sign extender/ALU) consumes entry.
REQ-010 Port: out_opcode  output  6  instr[31:26] of head entry.
REQ-011 Port: out_rs, out_rt  output  5 each  instr[25:21], instr[20:16].
REQ-012 Port: out_imm  output  16  instr[15:0]; feeds the sign extender input.
REQ-013 Port: out_sign  output  1  1 = sign-extend, 0 = zero-extend; feeds the sign extender select.
REQ-014 Port: out_itype  output  1  head entry is an I-type instruction.
REQ-015 Port: out_illegal  output  1  head entry opcode unrecognised.
REQ-016 Port: illegal_count  output  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-017 Storage SHALL be a 2-entry FIFO (skid buffer) holding decoded fields; count states EMPTY(0), ONE(1), FULL(2).
REQ-018 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 exactly when count != 2; out_valid SHALL be 1 exactly when count != 0.
REQ-020 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE->ONE on accept+pop; FULL->ONE on pop; all others hold.
REQ-021 Latency: instruction accepted at edge N SHALL appear on out_* after edge N (1 cycle) when the FIFO was empty; order SHALL be preserved.
REQ-022 Decode at accept: sign=1, itype=1 for opcodes 0x04,0x05,0x08,0x09,0x0A,0x0B,0x23,0x2B; sign=0, itype=1 for 0x0C,0x0D,0x0E,0x0F.
REQ-023 Opcodes 0x00, 0x02, 0x03 SHALL decode itype=0, sign=0, illegal=0, with imm still carried.
REQ-024 Any other opcode SHALL decode itype=0, sign=0, illegal=1 (subject to REQ-032).
REQ-025 out_* fields SHALL be the head entry; when out_valid=0 they SHALL be all zero.
REQ-026 flush=1 SHALL force count to 0 at the next edge; a same-cycle accept SHALL be discarded and not counted; a same-cycle pop is lost.
REQ-027 illegal_count SHALL increment by 1 on each accepted illegal instruction (flush low) and saturate at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-028 Inputs when in_ready=0 SHALL be ignored; no data overwrite in FULL.

Reset
REQ-029 On rising clk with rst_n=0: count=0, both entries zero, illegal_count=0.
REQ-030 After reset: out_valid=0, in_ready=1, all out_* fields 0, out_illegal=0.
REQ-031 Reset SHALL dominate flush and any handshake in the same cycle, including mid-FULL.

Configuration
REQ-032 Macro DECODE_ILLEGAL_TRAP_EN: defined -> illegal detection and illegal_count per REQ-024/027; undefined -> out_illegal tied 0, illegal_count tied 0, no counter logic, unknown opcodes decode itype=0, sign=0.

Verification
REQ-033 Reset then in_instr=0x2008FF00 (addi) valid one cycle, out_ready=1 -> next cycle out_valid=1, out_opcode=0x08, out_imm=0xFF00, out_sign=1, out_itype=1.
REQ-034 Push 0x3108FF00 (andi) then 0x8D0B0004 (lw) with out_ready=0 -> in_ready=0 after two accepts; release out_ready -> andi (sign=0) then lw (sign=1, imm=0x0004) in order.
REQ-035 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_count unchanged.
REQ-036 With DECODE_ILLEGAL_TRAP_EN, accept opcode 0x3F 300 times (CNT_W=8) -> out_illegal=1 per entry, illegal_count stops at 255; without macro -> out_illegal=0, illegal_count=0.
REQ-037 FULL then rst_n=0 for one edge with flush=0, in_valid=1 -> out_valid=0, in_ready=1, illegal_count=0.
